// File: rtl/aes_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : aes_pkg                                                       |
// | Purpose  : Shared AES definitions: key-word generator state encoding,    |
// |            AES-128 geometry constants and the GF(2^8) xtime helper.      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int         WORDS_PER_ROUND = 4;
    localparam int         AES128_ROUNDS   = 10;
    localparam logic [7:0] RCON_INIT       = 8'h01;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : aes_sbox                                                      |
// | Purpose  : Combinational AES forward S-box, one byte in, one byte out.   |
// | Ports    : i_byte [7:0] in  - byte to substitute                         |
// |            o_byte [7:0] out - S-box image of i_byte                      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    // Entry 0 sits in the top byte, so entry x starts at bit 2047 - 8*x.
    localparam logic [2047:0] c_table = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // 2047 - 8*x == {~x, 3'b111}: avoids a subtractor in the index.
    assign o_byte = c_table[{~i_byte, 3'b111} -: 8];

endmodule
`default_nettype wire

// File: rtl/aes_key_word_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : aes_key_word_gen                                              |
// | Purpose  : On-the-fly AES-128 key expansion, one 32-bit round-key word   |
// |            per cycle with its column index, one round per request.      |
// | Ports    : clk            in   system clock, rising edge                 |
// |            reset          in   synchronous active-high reset             |
// |            key_load       in   capture key_in, restart at round 0        |
// |            key_in[127:0]  in   cipher key, word 0 = key_in[127:96]       |
// |            next_round     in   request next round (honoured in WAIT)     |
// |            word_valid     out  word/idx valid this cycle                 |
// |            word_idx[2:0]  out  column index 0..3                         |
// |            round_key_word out  w[4r+word_idx]                            |
// |            round_num[3:0] out  round r of the presented word             |
// |            busy           out  round being emitted                       |
// |            done           out  final round fully emitted                 |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module aes_key_word_gen
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES128_ROUNDS
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         key_load,
    input  logic [127:0] key_in,
    input  logic         next_round,
    output logic         word_valid,
    output logic [2:0]   word_idx,
    output logic [31:0]  round_key_word,
    output logic [3:0]   round_num,
    output logic         busy,
    output logic         done
);

    localparam logic [3:0] c_last_round = 4'(NUM_ROUNDS);
    localparam logic [1:0] c_last_col   = 2'(WORDS_PER_ROUND - 1);

    state_t        r_state, w_state_nxt;
    logic [1:0]    r_col, w_col_nxt;
    logic          r_gen, w_gen_nxt;      // 0: replay loaded key, 1: derive next round
    logic [127:0]  r_kreg, w_kreg_nxt;
    logic [7:0]    r_rcon, w_rcon_nxt;
    logic          r_word_valid, w_word_valid_nxt;
    logic [2:0]    r_word_idx, w_word_idx_nxt;
    logic [31:0]   r_round_key_word, w_round_key_word_nxt;
    logic [3:0]    r_round_num, w_round_num_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_done, w_done_nxt;

    logic [31:0]   w_kw [4];
    logic [31:0]   w_prev;
    logic [31:0]   w_rot;
    logic [31:0]   w_sub;
    logic [31:0]   w_new;
    logic [31:0]   w_emit_word;

    always_comb begin
        for (int j = 0; j < 4; j++) begin
            w_kw[j] = r_kreg[127 - 32*j -: 32];
        end
    end

    // Column j-1 has already been overwritten with this round's value; at
    // column 0 the index wraps to 3, which still holds last round's word 3.
    assign w_prev = w_kw[r_col - 2'd1];
    assign w_rot  = {w_prev[23:0], w_prev[31:24]};

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_sbox
            aes_sbox u_sbox (
                .i_byte (w_rot[8*g +: 8]),
                .o_byte (w_sub[8*g +: 8])
            );
        end
    endgenerate

    assign w_new       = (r_col == 2'd0) ? (w_kw[0] ^ w_sub ^ {r_rcon, 24'h0})
                                         : (w_kw[r_col] ^ w_prev);
    assign w_emit_word = r_gen ? w_new : w_kw[r_col];

    always_comb begin
        w_state_nxt          = r_state;
        w_col_nxt            = r_col;
        w_gen_nxt            = r_gen;
        w_kreg_nxt           = r_kreg;
        w_rcon_nxt           = r_rcon;
        w_word_valid_nxt     = 1'b0;
        w_word_idx_nxt       = 3'd0;
        w_round_key_word_nxt = r_round_key_word;
        w_round_num_nxt      = r_round_num;
        w_busy_nxt           = 1'b0;
        w_done_nxt           = r_done;

        if (key_load) begin
            w_kreg_nxt  = key_in;
            w_rcon_nxt  = RCON_INIT;
            w_state_nxt = EMIT;
            w_col_nxt   = 2'd0;
            w_gen_nxt   = 1'b0;
            w_done_nxt  = 1'b0;
        end else begin
            case (r_state)
                WAIT: begin
                    if (next_round && (r_round_num < c_last_round)) begin
                        w_state_nxt = EMIT;
                        w_col_nxt   = 2'd0;
                        w_gen_nxt   = 1'b1;
                    end
                end
                EMIT: begin
                    w_word_valid_nxt     = 1'b1;
                    w_word_idx_nxt       = {1'b0, r_col};
                    w_round_key_word_nxt = w_emit_word;
                    w_busy_nxt           = 1'b1;
                    if (r_col == 2'd0) begin
                        w_round_num_nxt = r_gen ? (r_round_num + 4'd1) : 4'd0;
                    end
                    if (r_gen) begin
                        case (r_col)
                            2'd0:    w_kreg_nxt[127:96] = w_new;
                            2'd1:    w_kreg_nxt[95:64]  = w_new;
                            2'd2:    w_kreg_nxt[63:32]  = w_new;
                            default: w_kreg_nxt[31:0]   = w_new;
                        endcase
                    end
                    w_col_nxt = r_col + 2'd1;
                    if (r_col == c_last_col) begin
                        if (r_gen) begin
                            w_rcon_nxt = xtime(r_rcon);
                        end
                        // round_num already holds this round (set at column 0).
                        w_state_nxt = (r_round_num == c_last_round) ? DONE : WAIT;
                    end
                end
                DONE: begin
                    w_done_nxt = 1'b1;
                end
                IDLE: begin
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= IDLE;
            r_col            <= 2'd0;
            r_gen            <= 1'b0;
            r_kreg           <= '0;
            r_rcon           <= RCON_INIT;
            r_word_valid     <= 1'b0;
            r_word_idx       <= 3'd0;
            r_round_key_word <= '0;
            r_round_num      <= 4'd0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_col            <= w_col_nxt;
            r_gen            <= w_gen_nxt;
            r_kreg           <= w_kreg_nxt;
            r_rcon           <= w_rcon_nxt;
            r_word_valid     <= w_word_valid_nxt;
            r_word_idx       <= w_word_idx_nxt;
            r_round_key_word <= w_round_key_word_nxt;
            r_round_num      <= w_round_num_nxt;
            r_busy           <= w_busy_nxt;
            r_done           <= w_done_nxt;
        end
    end

    assign word_valid     = r_word_valid;
    assign word_idx       = r_word_idx;
    assign round_key_word = r_round_key_word;
    assign round_num      = r_round_num;
    assign busy           = r_busy;
    assign done           = r_done;

endmodule
`default_nettype wire
